eflags_commit_reg: RTL and testbench

- Architectural EFLAGS register that sits directly downstream of the flag-generation logic (OF/PF/ZF generators and the 32-bit flag assembly).
- Merges each writeback's flag word into the stored EFLAGS under a per-bit write mask.
- Tracks in-flight flag writers with an up/down counter, so flag consumers (Jcc, SETcc, ADC/SBB, string ops using DF) stall until the flags they need are committed or forwardable.

---
 rtl/eflags_commit_reg_pkg.sv | 37 +++
 rtl/flag_pend_counter.sv | 58 +++++
 rtl/eflags_commit_reg.sv | 66 ++++++
 tb/tb_eflags_commit_reg.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/eflags_commit_reg_pkg.sv
// Shared EFLAGS definitions: bit positions, writable-bit mask and per-class update masks.
// Imported by the flag register, decode and ALU stages.
package eflags_commit_reg_pkg;

  localparam int unsigned FLAG_W = 32;

  localparam int unsigned OF_BIT = 11;
  localparam int unsigned DF_BIT = 10;
  localparam int unsigned SF_BIT = 7;
  localparam int unsigned ZF_BIT = 6;
  localparam int unsigned AF_BIT = 4;
  localparam int unsigned PF_BIT = 2;
  localparam int unsigned CF_BIT = 0;

  localparam logic [FLAG_W-1:0] WR_MASK    = 32'h0000_0CD5;
  localparam logic [FLAG_W-1:0] MASK_ARITH = 32'h0000_08D5;
  localparam logic [FLAG_W-1:0] MASK_LOGIC = 32'h0000_08C5;
  localparam logic [FLAG_W-1:0] MASK_INC   = 32'h0000_08D4;
  localparam logic [FLAG_W-1:0] MASK_DF    = 32'h0000_0400;

  typedef enum logic [1:0] {
    CntHold,
    CntInc,
    CntDec,
    CntClr
  } cnt_op_e;

  // Bits outside WR_MASK can never be set, whatever the caller's mask says.
  function automatic logic [FLAG_W-1:0] merge_flags(input logic [FLAG_W-1:0] cur,
                                                    input logic [FLAG_W-1:0] upd,
                                                    input logic [FLAG_W-1:0] mask);
    logic [FLAG_W-1:0] eff;
    eff = mask & WR_MASK;
    return (cur & ~eff) | (upd & eff);
  endfunction

endpackage

// File: rtl/flag_pend_counter.sv
// Saturating up/down counter of in-flight flag writers with synchronous clear and
// single-cycle overflow/underflow pulses.
module flag_pend_counter
  import eflags_commit_reg_pkg::*;
#(
  parameter int unsigned PEND_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  input  logic              clr,
  output logic [PEND_W-1:0] cnt,
  output logic              ovf,
  output logic              unf
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0] cnt_q, cnt_d;
  cnt_op_e           op;

  always_comb begin
    op = CntHold;
    if (clr) begin
      op = CntClr;
    end else if (inc && !dec) begin
      op = CntInc;
    end else if (dec && !inc) begin
      op = CntDec;
    end
  end

  // Overflow is not qualified by clr: an issue into a full counter is an error either way.
  assign ovf = inc & ~dec & (cnt_q == CNT_MAX);
  assign unf = dec & ~inc & ~clr & (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    unique case (op)
      CntInc:  cnt_d = ovf ? cnt_q : cnt_q + 1'b1;
      CntDec:  cnt_d = unf ? cnt_q : cnt_q - 1'b1;
      CntClr:  cnt_d = '0;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/eflags_commit_reg.sv
// Architectural EFLAGS register: masked merge of writeback flags, same-cycle forwarding
// and consumer stall based on the number of in-flight flag writers.
module eflags_commit_reg
  import eflags_commit_reg_pkg::*;
#(
  parameter int unsigned       PEND_W      = 3,
  parameter logic [FLAG_W-1:0] RESET_FLAGS = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  input  logic              wb_valid,
  input  logic [FLAG_W-1:0] wb_flags,
  input  logic [FLAG_W-1:0] wb_mask,
  input  logic              flush,
  input  logic              rd_req,
  output logic [FLAG_W-1:0] flags_out,
  output logic [FLAG_W-1:0] flags_fwd,
  output logic              rd_stall,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              err
);

  logic [FLAG_W-1:0] flags_q;
  logic [FLAG_W-1:0] merged;
  logic              err_q;
  logic              ovf, unf;
  logic [PEND_W-1:0] stall_thresh;

  flag_pend_counter #(
    .PEND_W(PEND_W)
  ) u_pend (
    .clk  (clk),
    .reset(reset),
    .inc  (iss_valid),
    .dec  (wb_valid),
    .clr  (flush),
    .cnt  (pend_cnt),
    .ovf  (ovf),
    .unf  (unf)
  );

  assign merged = merge_flags(flags_q, wb_flags, wb_mask);

  // A writeback in a flush cycle is older than the flush, so it still commits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= RESET_FLAGS & WR_MASK;
      err_q   <= 1'b0;
    end else begin
      if (wb_valid) begin
        flags_q <= merged;
      end
      err_q <= err_q | ovf | unf;
    end
  end

  assign flags_out = flags_q;
  assign flags_fwd = wb_valid ? merged : flags_q;
  assign err       = err_q;

  // The writer committing this cycle is covered by forwarding, so it does not block.
  assign stall_thresh = PEND_W'(wb_valid);
  assign rd_stall     = rd_req & (pend_cnt > stall_thresh);

endmodule

// File: tb/tb_eflags_commit_reg.sv
// Randomised and directed bench for eflags_commit_reg with a queue-based scoreboard
// checked against an integer-level reference model.
module tb_eflags_commit_reg;

  localparam logic [31:0] WRM        = 32'h0000_0CD5;
  localparam logic [31:0] M_ARITH    = 32'h0000_08D5;
  localparam logic [31:0] M_LOGIC    = 32'h0000_08C5;
  localparam logic [31:0] M_INC      = 32'h0000_08D4;
  localparam logic [31:0] M_DF       = 32'h0000_0400;
  localparam int          MAX_PEND   = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic        iss_valid, wb_valid, flush, rd_req;
  logic [31:0] wb_flags, wb_mask;
  logic [31:0] flags_out, flags_fwd;
  logic        rd_stall;
  logic [2:0]  pend_cnt;
  logic        err;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [31:0] fwd;
    logic        stall;
    logic [31:0] out;
    int          cnt;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [31:0] m_flags;
  int          m_pend;
  bit          m_err;

  eflags_commit_reg dut (
    .clk      (clk),
    .reset    (reset),
    .iss_valid(iss_valid),
    .wb_valid (wb_valid),
    .wb_flags (wb_flags),
    .wb_mask  (wb_mask),
    .flush    (flush),
    .rd_req   (rd_req),
    .flags_out(flags_out),
    .flags_fwd(flags_fwd),
    .rd_stall (rd_stall),
    .pend_cnt (pend_cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] commit(input logic [31:0] cur, input logic [31:0] f,
                                         input logic [31:0] m);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 32; b++) begin
      if (m[b] && WRM[b]) r[b] = f[b];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs; compare mid-cycle against the scoreboard.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("flags_fwd", flags_fwd, e.fwd);
      check("rd_stall", {31'd0, rd_stall}, {31'd0, e.stall});
      check("flags_out", flags_out, e.out);
      check("pend_cnt", {29'd0, pend_cnt}, e.cnt);
      check("err", {31'd0, err}, {31'd0, e.err});
    end
  end

  // Called just after a rising edge: drive one cycle of stimulus, predict, advance the model.
  task automatic step(input bit iss, input bit wb, input logic [31:0] f, input logic [31:0] m,
                      input bit fl, input bit rd);
    exp_t e;
    int   nxt;
    iss_valid = iss;
    wb_valid  = wb;
    wb_flags  = f;
    wb_mask   = m;
    flush     = fl;
    rd_req    = rd;
    e.out   = m_flags;
    e.fwd   = wb ? commit(m_flags, f, m) : m_flags;
    e.stall = rd && (m_pend > (wb ? 1 : 0));
    e.cnt   = m_pend;
    e.err   = m_err;
    exp_q.push_back(e);
    @(posedge clk);
    if (wb) m_flags = commit(m_flags, f, m);
    if (iss && !wb && m_pend == MAX_PEND) m_err = 1'b1;
    if (wb && !iss && m_pend == 0 && !fl) m_err = 1'b1;
    nxt = m_pend + int'(iss) - int'(wb);
    if (fl) nxt = 0;
    if (nxt > MAX_PEND) nxt = MAX_PEND;
    if (nxt < 0) nxt = 0;
    m_pend = nxt;
    #1;
  endtask

  task automatic idle(input bit rd);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, rd);
  endtask

  task automatic do_reset();
    iss_valid = 1'b0;
    wb_valid  = 1'b0;
    flush     = 1'b0;
    rd_req    = 1'b0;
    wb_flags  = '0;
    wb_mask   = '0;
    reset     = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    m_flags = 32'h0;
    m_pend  = 0;
    m_err   = 1'b0;
  endtask

  initial begin
    do_reset();

    // Idle after reset; consumer never stalls with nothing pending
    idle(1'b1);
    idle(1'b1);

    // Masked commit: CF and non-writable bits stay 0
    step(1'b0, 1'b1, 32'hFFFF_FFFF, M_INC, 1'b0, 1'b0);
    idle(1'b0);

    do_reset();
    // Two writers in flight, then drain with forwarding on the last one
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h0, M_ARITH, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0041, 32'hFFFF_FFFF, 1'b0, 1'b1);
    idle(1'b1);

    // Issue and writeback together hold the count; flush with a DF writeback
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0001, M_LOGIC, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0400, M_DF, 1'b1, 1'b1);
    idle(1'b1);

    // Saturate at 7 and flag overflow; underflow afterwards keeps err set
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    idle(1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0080, M_ARITH, 1'b0, 1'b1);
    idle(1'b1);

    // Asynchronous reset mid-cycle with state loaded
    do_reset();
    step(1'b1, 1'b1, 32'hFFFF_FFFF, M_ARITH, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle(1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("async flags_out", flags_out, 32'h0);
    check("async pend_cnt", {29'd0, pend_cnt}, 32'd0);
    check("async err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    m_flags = 32'h0;
    m_pend  = 0;
    m_err   = 1'b0;
    idle(1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] f, m;
      int          sel;
      f   = $urandom;
      sel = $urandom_range(0, 4);
      case (sel)
        0:       m = M_ARITH;
        1:       m = M_LOGIC;
        2:       m = M_INC;
        3:       m = M_DF;
        default: m = $urandom;
      endcase
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), f, m,
           ($urandom_range(0, 15) == 0), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    // Let the monitor drain; a stuck queue counts as a failure
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
